// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of a 64-bit single-port SRAM
module sram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 4,
  parameter int INIT_CLEAR = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0]                req_we_i,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [127:0]              req_wdata_i,
  input  logic [15:0]               req_wmask_i,
  output logic [1:0]                rsp_valid_o,
  output logic [63:0]               rsp_rdata_o,
  output logic                      init_done_o,
  output logic                      sram_csb_o,
  output logic                      sram_we_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr_o,
  output logic [63:0]               sram_wdata_o,
  output logic [7:0]                sram_wmask_o,
  input  logic [63:0]               sram_rdata_i
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clr_issue;
  logic                    rr_ptr;      // port preferred on a tie (the one not granted last)
  logic                    gnt_port;
  logic                    hs;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [63:0]             sel_wdata;
  logic [7:0]              sel_wmask;
  logic [RD_LATENCY-1:0]   pipe_v;
  logic [RD_LATENCY-1:0]   pipe_p;

  // State register; reset always returns to RESET so a clear restarts from address 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; CLEAR issues one zero write per cycle and leaves on the last address
  always_comb begin
    state_next = state;
    clr_issue  = 1'b0;
    case (state)
      ST_RESET: begin
        state_next = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        clr_issue = 1'b1;
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // Grant selection: a lone requester wins, a tie goes to the pointer; ready shows the would-be winner
  always_comb begin
    gnt_port    = rr_ptr;
    req_ready_o = 2'b00;
    case (req_valid_i)
      2'b01:   gnt_port = 1'b0;
      2'b10:   gnt_port = 1'b1;
      default: gnt_port = rr_ptr;
    endcase
    if (state == ST_RUN) begin
      req_ready_o = gnt_port ? 2'b10 : 2'b01;
    end
  end

  assign hs        = |(req_valid_i & req_ready_o);
  assign sel_we    = gnt_port ? req_we_i[1] : req_we_i[0];
  assign sel_addr  = gnt_port ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign sel_wdata = gnt_port ? req_wdata_i[127:64] : req_wdata_i[63:0];
  assign sel_wmask = gnt_port ? req_wmask_i[15:8] : req_wmask_i[7:0];

  // Clear address counter, advanced once per zero write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_cnt <= '0;
    end else if (clr_issue) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Round-robin pointer moves only when a request is actually accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= 1'b0;
    end else if (hs) begin
      rr_ptr <= ~gnt_port;
    end
  end

  // Registered SRAM command; idle cycles deselect but keep address/data stable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sram_csb_o   <= 1'b1;
      sram_we_o    <= 1'b1;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;
    end else if (clr_issue) begin
      sram_csb_o   <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_addr_o  <= clr_cnt;
      sram_wdata_o <= '0;
      sram_wmask_o <= 8'hFF;
    end else if (hs) begin
      sram_csb_o   <= 1'b0;
      sram_we_o    <= ~sel_we;
      sram_addr_o  <= sel_addr;
      sram_wdata_o <= sel_wdata;
      sram_wmask_o <= sel_wmask;
    end else begin
      sram_csb_o   <= 1'b1;
      sram_we_o    <= 1'b1;
    end
  end

  // Response pipe tracks which port owns each in-flight access; reset drops them all
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v <= '0;
      pipe_p <= '0;
    end else begin
      pipe_v[0] <= hs;
      pipe_p[0] <= gnt_port;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_p[k] <= pipe_p[k-1];
      end
    end
  end

  assign rsp_valid_o = pipe_v[RD_LATENCY-1] ? (pipe_p[RD_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata_o = pipe_v[RD_LATENCY-1] ? sram_rdata_i : 64'h0;
  assign init_done_o = (state == ST_RUN);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural memory model
module tb_sram_arbiter;
  localparam int AW    = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [127:0]    req_wdata;
  logic [15:0]     req_wmask;
  logic [63:0]     rsp_rdata;
  logic            init_done, sram_csb, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [63:0]     sram_wdata, sram_rdata;
  logic [7:0]      sram_wmask;

  typedef struct {
    int          due;
    int          port;
    bit          we;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          in_run = 0;
  int          last_gnt = 1;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] smem [DEPTH];
  logic [63:0] sdly [LAT];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT), .INIT_CLEAR(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .init_done_o(init_done),
    .sram_csb_o(sram_csb), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // SRAM macro stand-in: write lands on the edge after issue, read data delayed to LAT-1 edges
  always @(posedge clk) begin
    logic [63:0] w;
    if (!sram_csb && !sram_we) begin
      w = smem[sram_addr];
      for (int b = 0; b < 8; b++) if (sram_wmask[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      smem[sram_addr] <= w;
    end
    sdly[1] <= smem[sram_addr];
    for (int k = 2; k < LAT; k++) sdly[k] <= sdly[k-1];
  end
  assign sram_rdata = sdly[LAT-1];

  // Cycle count; a reset edge discards every response not yet due
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
  end

  // Reference arbiter and memory: decide the winner, predict the response, queue it
  always @(negedge clk) begin
    int          g;
    logic [63:0] bm, wd;
    int          a;
    exp_t        e;
    if (!rst && in_run) begin
      if (req_valid == 2'b01) g = 0;
      else if (req_valid == 2'b10) g = 1;
      else g = 1 - last_gnt;
      chk("req_ready", {62'b0, req_ready}, (g == 1) ? 64'd2 : 64'd1);
      if (req_valid[g]) begin
        a  = int'(req_addr[g*AW +: AW]);
        wd = req_wdata[g*64 +: 64];
        for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{req_wmask[g*8 + b]}};
        e.due  = cyc + LAT;
        e.port = g;
        e.we   = req_we[g];
        if (req_we[g]) begin
          ref_mem[a] = (ref_mem[a] & ~bm) | (wd & bm);
          e.data = 64'h0;
        end else begin
          e.data = ref_mem[a];
        end
        sb.push_back(e);
        last_gnt = g;
      end
    end
  end

  // Response monitor: every strobe must match the oldest queued prediction on its due cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL rsp_missing: port %0d due cycle %0d, now %0d", e.port, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", {62'b0, rsp_valid}, (e.port == 1) ? 64'd2 : 64'd1);
      if (!e.we) chk("rsp_rdata", rsp_rdata, e.data);
    end else if (rsp_valid != 2'b00) begin
      chk("rsp_unexpected", {62'b0, rsp_valid}, 64'd0);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(int p, bit v, bit we, int a, logic [63:0] d, logic [7:0] m);
    req_valid[p]           = v;
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = AW'(a);
    req_wdata[p*64 +: 64]  = d;
    req_wmask[p*8 +: 8]    = m;
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 64'h0, 8'h0);
    set_req(1, 0, 0, 0, 64'h0, 8'h0);
  endtask

  task automatic reset_and_clear();
    bit found;
    rst      = 1'b1;
    in_run   = 1'b0;
    last_gnt = 1;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("rst_csb", sram_csb, 1);
    chk("rst_sram_we", sram_we, 1);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_sram_wmask", sram_wmask, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'h0;
    found = 0;
    for (int t = 0; t < 4 && !found; t++) begin
      @(negedge clk);
      chk("pre_clear_ready", req_ready, 0);
      if (!sram_csb) found = 1;
    end
    chk("clear_start", found, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      chk("clear_csb", sram_csb, 0);
      chk("clear_we", sram_we, 0);
      chk("clear_addr", sram_addr, i);
      chk("clear_wdata", sram_wdata, 0);
      chk("clear_wmask", sram_wmask, 8'hFF);
      chk("clear_init_done", init_done, (i == DEPTH - 1) ? 1 : 0);
      if (i < DEPTH - 1) chk("clear_ready", req_ready, 0);
      if (i == DEPTH - 3) begin
        @(posedge clk);
        #1 req_valid = 2'b00;
      end
    end
    in_run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) smem[i] = {$urandom(), $urandom()};
    for (int k = 0; k < LAT; k++) sdly[k] = 64'h0;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Zero-fill after reset, then service
    reset_and_clear();
    step(1);

    // Port 1 write then read of the same word
    idle();
    set_req(1, 1, 1, 5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    step(1);
    set_req(1, 1, 0, 5, 64'h0, 8'h00);
    step(1);
    idle();
    step(LAT + 2);

    // Byte-masked write over a zeroed word
    set_req(0, 1, 1, 3, 64'h0, 8'hFF);
    step(1);
    set_req(0, 1, 1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    step(1);
    set_req(0, 1, 0, 3, 64'h0, 8'h00);
    step(1);
    idle();
    step(LAT + 2);

    // Both ports contending for six cycles
    set_req(0, 1, 0, 5, 64'h0, 8'h00);
    set_req(1, 1, 0, 3, 64'h0, 8'h00);
    step(6);
    idle();
    step(LAT + 2);

    // Port 0 streaming alone
    set_req(0, 1, 0, 3, 64'h0, 8'h00);
    step(4);
    idle();
    step(LAT + 2);

    // Random traffic with address collisions across a small array
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        set_req(p, ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      end
      step(1);
    end
    idle();
    step(LAT + 2);

    // Reset with three reads in flight
    set_req(0, 1, 0, 5, 64'h0, 8'h00);
    step(3);
    idle();
    reset_and_clear();
    step(1);

    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < 2; p++) begin
        set_req(p, ($urandom_range(0, 1) != 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      end
      step(1);
    end
    idle();
    step(LAT + 3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
